// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word and shifts it out one bit per cycle.
// Latency: word accepted at edge k drives sout for the WIDTH cycles after k, with no gap on back-to-back loads.
// Backpressure: load_ready is high in IDLE and on the final bit only; abort cancels the frame and wins over a load.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             head;
    logic             accept;

    assign head = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        busy       = (state == SHIFT);
        sout_valid = busy;
        sout       = busy & head;
        last       = busy && (cnt == CW'(WIDTH - 1));
        // rst gates ready combinationally so no load can look accepted while reset is held
        load_ready = !rst && (!busy || last);
        accept     = load_valid && load_ready && !abort;

        if (abort) begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
        end else if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = din;
            cnt_nxt   = '0;
        end else begin
            case (state)
                SHIFT: begin
                    shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg[WIDTH-1:1]};
                    if (last) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
